dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data_memory port between the pipeline MEM stage (core) and a boot/DMA
//  loader port. Core has default priority; a starvation counter guarantees loader progress.
//  Loader bursts lock the port until the last beat. Sits between mem_stage and data_memory.
//  Drives core_stall so hazard logic can freeze the pipeline.
// PARAMETERS
//  ADDR_W    10  byte-address width presented to data_memory
//  MAX_WAIT  4   consecutive cycles the loader may lose to the core before it is forced a grant (>=1)
//  CNT_W     16  width of statistics counters (DMEM_ARB_STATS_EN only)
// PORTS
//  clk            in   1       system clock
//  reset_n        in   1       synchronous reset, active low
//  core_req       in   1       core access request (load or store this cycle)
//  core_we        in   1       core store
//  core_addr      in   ADDR_W  core byte address
//  core_wdata     in   32      core store data
//  core_size      in   2       access size, passed to mem_size
//  core_sign      in   1       load sign-extend, passed to mem_sign
//  core_gnt       out  1       core access performed this cycle
//  core_rdata     out  32      core load data, valid when core_gnt
//  core_stall     out  1       core_req & ~core_gnt
//  ldr_req        in   1       loader beat request
//  ldr_we/ldr_addr/ldr_wdata/ldr_size/ldr_sign  in  1/ADDR_W/32/2/1  as core_*
//  ldr_last       in   1       current beat is the final beat of a burst
//  ldr_gnt        out  1       loader beat performed this cycle
//  ldr_rdata      out  32      loader read data, valid when ldr_gnt
//  mem_addr/mem_we/mem_wdata/mem_size/mem_sign  out  ADDR_W/1/32/2/1  to data_memory
//  mem_rdata      in   32      data_memory read data (combinational read)
//  core_gnt_cnt   out  CNT_W   core grants (DMEM_ARB_STATS_EN only)
//  ldr_gnt_cnt    out  CNT_W   loader grants (DMEM_ARB_STATS_EN only)
// BEHAVIOUR
//  - One clock (clk); synchronous active-low reset (reset_n). Registers: state {ARB, LOCK}, starve_cnt.
//  - Reset: state=ARB, starve_cnt=0, counters=0. While reset_n=0: core_gnt=ldr_gnt=0,
//    mem_we=0, mem_addr=0, rdata outs=0.
//  - Selection (combinational, same cycle; zero added latency; write commits at clk edge):
//    LOCK: sel=LDR if ldr_req, else NONE (core never granted in LOCK).
//    ARB: sel=LDR if ldr_req & (~core_req | starve_cnt==MAX_WAIT); else CORE if core_req; else NONE.
//  - core_gnt = sel==CORE; ldr_gnt = sel==LDR. Beat transferred iff gnt=1; requester holds
//    req and fields stable until gnt.
//  - Mem mux: fields of selected requester; NONE -> mem_we=0, mem_addr=0, mem_wdata=0, size=0, sign=0.
//    mem_we never high without a grant. Unselected rdata out = 0.
//  - Transitions: ARB->LOCK when sel==LDR & ~ldr_last. LOCK->ARB when (ldr_gnt & ldr_last) | ~ldr_req.
//    A single-beat burst (ldr_last on first beat) stays in ARB.
//  - starve_cnt: +1 when ldr_req & sel==CORE, saturates at MAX_WAIT; cleared when sel==LDR or ~ldr_req.
//  - Simultaneous req in ARB with starve_cnt<MAX_WAIT: core wins, loader waits.
//  - Reset mid-burst: LOCK abandoned, state=ARB; loader must restart burst.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined: core_gnt_cnt/ldr_gnt_cnt ports exist, +1 per grant, wrap
//    modulo 2^CNT_W, cleared by reset.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Core only: core_req=1, we=1, addr=0x010, wdata=0xDEADBEEF, size=word; then read 0x010
//    -> core_gnt=1 both cycles, stall=0, rdata=0xDEADBEEF.
//  2 Both request continuously, MAX_WAIT=4, ldr_last=1 -> core granted 4 cycles, ldr_gnt on 5th,
//    starve_cnt back to 0, core_stall=1 that cycle only.
//  3 Loader 4-beat burst to 0x100..0x10C while core_req=1 -> once first beat granted,
//    ldr_gnt 4 consecutive cycles, core_stall=1 throughout, state ARB after beat with ldr_last.
//  4 Loader drops ldr_req mid-burst (after beat 2) -> LOCK->ARB next edge, core granted next cycle.
//  5 reset_n=0 for one cycle mid-burst -> gnts=0, mem_we=0 that cycle; state=ARB and
//    starve_cnt=0 afterwards; with STATS_EN both counters read 0.
//  6 No requests -> mem_we=0, mem_addr=0, both gnt=0, stall=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter: shares data_memory between the core MEM stage and a loader port
// Optional build macro: DMEM_ARB_STATS_EN (adds grant counters)
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 4
`ifdef DMEM_ARB_STATS_EN
  ,
  parameter int CNT_W    = 16
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  input  logic [1:0]        core_size,
  input  logic              core_sign,
  output logic              core_gnt,
  output logic [31:0]       core_rdata,
  output logic              core_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [31:0]       ldr_wdata,
  input  logic [1:0]        ldr_size,
  input  logic              ldr_sign,
  input  logic              ldr_last,
  output logic              ldr_gnt,
  output logic [31:0]       ldr_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic [1:0]        mem_size,
  output logic              mem_sign,
  input  logic [31:0]       mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  core_gnt_cnt,
  output logic [CNT_W-1:0]  ldr_gnt_cnt
`endif
);

  localparam int SW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [SW-1:0] C_MAX_WAIT = SW'(MAX_WAIT);

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_CORE = 2'd1,
    SEL_LDR  = 2'd2
  } sel_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  sel_t          sel;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_ARB;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Selection is forced to NONE during reset so no grant or write can leak out.
  always_comb begin
    sel      = SEL_NONE;
    state_d  = state_q;
    starve_d = starve_q;
    if (reset_n) begin
      case (state_q)
        ST_LOCK: begin
          if (ldr_req) sel = SEL_LDR;
        end
        default: begin
          if (ldr_req && (!core_req || (starve_q == C_MAX_WAIT))) sel = SEL_LDR;
          else if (core_req)                                       sel = SEL_CORE;
        end
      endcase

      case (state_q)
        ST_LOCK: begin
          if (((sel == SEL_LDR) && ldr_last) || !ldr_req) state_d = ST_ARB;
        end
        default: begin
          if ((sel == SEL_LDR) && !ldr_last) state_d = ST_LOCK;
        end
      endcase

      if ((sel == SEL_LDR) || !ldr_req) begin
        starve_d = '0;
      end else if ((sel == SEL_CORE) && (starve_q != C_MAX_WAIT)) begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

  always_comb begin
    core_gnt   = 1'b0;
    ldr_gnt    = 1'b0;
    core_rdata = '0;
    ldr_rdata  = '0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    mem_size   = '0;
    mem_sign   = 1'b0;
    case (sel)
      SEL_CORE: begin
        core_gnt   = 1'b1;
        core_rdata = mem_rdata;
        mem_addr   = core_addr;
        mem_we     = core_we;
        mem_wdata  = core_wdata;
        mem_size   = core_size;
        mem_sign   = core_sign;
      end
      SEL_LDR: begin
        ldr_gnt    = 1'b1;
        ldr_rdata  = mem_rdata;
        mem_addr   = ldr_addr;
        mem_we     = ldr_we;
        mem_wdata  = ldr_wdata;
        mem_size   = ldr_size;
        mem_sign   = ldr_sign;
      end
      default: ;
    endcase
  end

  assign core_stall = core_req & ~core_gnt;

`ifdef DMEM_ARB_STATS_EN
  logic [CNT_W-1:0] core_cnt_q, core_cnt_d;
  logic [CNT_W-1:0] ldr_cnt_q, ldr_cnt_d;

  always_comb begin
    core_cnt_d = core_cnt_q + CNT_W'(core_gnt);
    ldr_cnt_d  = ldr_cnt_q + CNT_W'(ldr_gnt);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      core_cnt_q <= '0;
      ldr_cnt_q  <= '0;
    end else begin
      core_cnt_q <= core_cnt_d;
      ldr_cnt_q  <= ldr_cnt_d;
    end
  end

  assign core_gnt_cnt = core_cnt_q;
  assign ldr_gnt_cnt  = ldr_cnt_q;
`endif

endmodule

`default_nettype wire
